// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Iterative multiply/divide unit with architectural HI/LO.
//                MULT/MULTU use radix-2 shift-add (LSB first); DIV/DIVU use
//                restoring division (MSB first). 32 iterations plus one
//                sign-fix cycle. Divide support is compiled in only when
//                the MDU_DIV_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;        // multiplicand magnitude / dividend (shifts left)
    logic [31:0] r_b;        // multiplier (shifts right) / divisor magnitude
    logic [63:0] r_acc;      // product, or {remainder, quotient}
    logic        r_neg;      // product sign / quotient sign
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Operand conditioning at launch: signed ops (op[0]=0) use magnitudes.
    logic        w_signed;
    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    // Multiply step and final product sign fix.
    logic [32:0] w_mul_sum;
    logic [63:0] w_prod_fix;

    assign w_signed   = ~op[0];
    assign w_abs_a    = (w_signed && opa[31]) ? (~opa + 32'd1) : opa;
    assign w_abs_b    = (w_signed && opb[31]) ? (~opb + 32'd1) : opb;
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_b[0] ? r_a : 32'd0)};
    assign w_prod_fix = r_neg ? (~r_acc + 64'd1) : r_acc;

`ifdef MDU_DIV_EN
    logic        r_div;      // current op is a divide
    logic        r_neg_rem;  // remainder takes dividend sign
    logic        r_dz;       // divisor is zero
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Trial subtract: the remainder is always below the divisor, so the MSB of
    // the 33-bit difference is exactly the borrow. A zero divisor never
    // borrows, which yields an all-ones quotient and the dividend as remainder.
    assign w_shift   = {r_acc[63:32], r_a[31]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_qbit    = ~w_diff[32] | r_dz;
    // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
    assign w_quo_fix = (r_neg && !r_dz) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem_fix = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    assign w_accept  = start;
`else
    assign w_accept  = start & ~op[1];
`endif

    // Control FSM, iterative datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_acc   <= 64'd0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
`ifdef MDU_DIV_EN
            r_div     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_wr) r_hi <= wdata;
                    if (lo_wr) r_lo <= wdata;
                    if (w_accept) begin
                        r_a     <= w_signed ? w_abs_a : opa;
                        r_b     <= w_signed ? w_abs_b : opb;
                        r_acc   <= 64'd0;
                        r_cnt   <= 5'd0;
                        r_neg   <= w_signed & (opa[31] ^ opb[31]);
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
`ifdef MDU_DIV_EN
                        r_div     <= op[1];
                        r_neg_rem <= w_signed & opa[31];
                        r_dz      <= (opb == 32'd0);
`endif
                    end
                end
                S_CALC: begin
`ifdef MDU_DIV_EN
                    if (r_div) begin
                        r_acc <= {w_diff[32] && !r_dz ? w_shift[31:0] : w_diff[31:0],
                                  r_acc[30:0], w_qbit};
                        r_a   <= {r_a[30:0], 1'b0};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[31:1]};
                        r_b   <= {1'b0, r_b[31:1]};
                    end
`else
                    r_acc <= {w_mul_sum, r_acc[31:1]};
                    r_b   <= {1'b0, r_b[31:1]};
`endif
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
`ifdef MDU_DIV_EN
                    if (r_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
`else
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Self-checking bench for mdu. Stimulus pushes expected
//                {HI,LO} into a queue; a monitor pops on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_tests;
    int          n_fails;
    logic [63:0] exp_q[$];
    logic        prev_done;

    mdu u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .hi_wr (hi_wr),
        .lo_wr (lo_wr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result and be one cycle wide.
    initial begin
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h expected no result", hi, lo);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({hi, lo} !== e) begin
                        n_fails++;
                        $display("FAIL result: got hi=0x%08h lo=0x%08h expected hi=0x%08h lo=0x%08h",
                                 hi, lo, e[63:32], e[31:0]);
                    end
                end
                n_tests++;
                if (prev_done) begin
                    n_fails++;
                    $display("FAIL done_width: got done high 2+ cycles expected 1");
                end
            end
            prev_done = done;
        end
    end

    // Launch one op and wait for it; optionally pokes start+lo_wr while busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int poke_at);
        int n;
        exp_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == poke_at) begin
                start = 1'b1; lo_wr = 1'b1; wdata = 32'hDEAD_BEEF;
                op = 2'b01; opa = 32'd9; opb = 32'd9;
            end else begin
                start = 1'b0; lo_wr = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; lo_wr = 1'b0;
        check("busy_cycles", n, 33);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; opa = 32'd0; opb = 32'd0;
        hi_wr = 1'b0; lo_wr = 1'b0; wdata = 32'd0;
        n_tests = 0; n_fails = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
`ifdef MDU_DIV_EN
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op(2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 0);
`endif

        // MTHI in idle, then a busy-time start/MTLO that must be ignored.
        hi_wr = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_wr = 1'b0;
        check("mthi", hi, 32'h0000_1234);
        run_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 10);

        // Reset in the middle of a MULT abandons it.
        @(negedge clk);
        start = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 0);

`ifndef MDU_DIV_EN
        // Divide launch must be ignored when divide support is absent.
        begin
            logic seen_busy;
            hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h0000_AAAA;
            @(negedge clk);
            hi_wr = 1'b0; lo_wr = 1'b0;
            start = 1'b1; op = 2'b11; opa = 32'd10; opb = 32'd2;
            @(negedge clk);
            start = 1'b0;
            seen_busy = 1'b0;
            repeat (40) begin
                if (busy) seen_busy = 1'b1;
                @(negedge clk);
            end
            check("nodiv_busy", {31'd0, seen_busy}, 32'd0);
            check("nodiv_hi", hi, 32'h0000_AAAA);
            check("nodiv_lo", lo, 32'h0000_AAAA);
        end
`endif

        repeat (3) @(negedge clk);
        check("pending_results", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
